fir_rns_sequencer: RTL and testbench
====================================

// Module: fir_rns_sequencer
// PURPOSE
//  Stream-side controller for fir_rns. Accepts SIGNAL_COUNT input samples on a valid/ready port and drives
//  fir_rns addr/x/operation through LOAD, COMPUTE and READ. Waits for done, then streams the results out
//  on a valid/ready port. Sits between the system bus/stream logic and the int<->RNS convertor pair.
// PARAMETERS
//  SIGNAL_COUNT  10    samples per block; fir_addr runs 0..SIGNAL_COUNT-1
//  N             10    filter taps (passed through to fir_rns; not used internally)
//  DATA_W        32    sample / result width (integer domain)
//  TIMEOUT       1024  max cycles in COMPUTE waiting for fir_done
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       async, active-high
//  start        in   1       1-cycle pulse: begin a block (honoured only in IDLE)
//  busy         out  1       1 in any state except IDLE
//  err_timeout  out  1       sticky: COMPUTE timed out; cleared by accepted start
//  in_valid     in   1       input sample valid
//  in_ready     out  1       = 1 only in LOAD
//  in_data      in   DATA_W  input sample
//  out_valid    out  1       result valid
//  out_ready    in   1       downstream accepts result
//  out_data     out  DATA_W  result, registered
//  out_last     out  1       qualifies the final result of the block (with out_valid)
//  fir_addr     out  32      to fir_rns addr
//  fir_x        out  DATA_W  to int->RNS convertor (fir_rns x)
//  fir_op       out  2       to fir_rns operation: 00 idle, 01 load, 10 compute, 11 read
//  fir_y        in   DATA_W  from RNS->int convertor
//  fir_done     in   1       from fir_rns done
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; sample counter, timeout counter and wait flag cleared.
//  IDLE (op 00)
//   - start=1 -> LOAD, fir_addr=0, err_timeout<=0.
//   - in_valid is ignored (in_ready=0).
//  LOAD (op 01)
//   - Beat on in_valid&in_ready: fir_x<=in_data, fir_addr<=cnt, cnt<=cnt+1.
//   - No beat: fir_x and fir_addr hold.
//   - Beat with cnt==SIGNAL_COUNT-1 -> COMPUTE next cycle. fir_op=10 starts one cycle after the last write is presented.
//  COMPUTE (op 10)
//   - tcnt increments each cycle.
//   - fir_done=1 -> READ, fir_addr<=0.
//   - tcnt==TIMEOUT-1 and no fir_done -> err_timeout<=1, state IDLE, op 00.
//   - fir_done seen in IDLE/LOAD is ignored.
//  READ (op 11), per address
//   - Sub-step WAIT: 1 cycle after fir_addr changes, for the converter path. Then out_data<=fir_y, out_valid<=1.
//   - out_last<=1 when fir_addr==SIGNAL_COUNT-1.
//   - While out_valid&!out_ready: out_data, out_last and fir_addr hold.
//   - On accept: out_valid<=0. If not last, fir_addr+1 and WAIT again; if last -> IDLE, op 00, fir_addr 0.
//   - Throughput: 1 result per 2 cycles max.
//  Boundaries
//   - start while busy: ignored.
//   - out_ready high with out_valid low: no effect.
//   - reset mid-operation: immediate return to IDLE; a partial block is discarded; fir_rns sees op 00.
//   - SIGNAL_COUNT=1: one LOAD beat, one result with out_last=1.
//  Widths
//   - cnt and tcnt use $clog2 sizing; fir_addr is zero-extended to 32 bits.
//   - No arithmetic on data: pure transport.
// TESTING
//  1. Assert reset for 3 cycles mid-clock -> all outputs 0 immediately, busy=0, fir_op=00.
//  2. start; stream 0..9 back-to-back; fir model raises done 5 cycles into COMPUTE; out_ready=1
//     -> fir_addr/fir_x pairs (k,k); results at fir_addr 0..9; out_last only on 10th; busy=0 after.
//  3. As 2, out_ready toggles 1,0,0,1 -> out_data/out_last stable while stalled; no result lost or repeated.
//  4. in_valid gaps (valid every 3rd cycle) -> fir_op stays 01; fir_addr advances only on beats.
//  5. fir_done held 0 -> after TIMEOUT cycles in COMPUTE: err_timeout=1, IDLE, fir_op=00; next start clears err.
//  6. reset after 4 LOAD beats, then start and 10 samples -> loading restarts at fir_addr 0; full block correct.

Source files
------------

// File: rtl/fir_rns_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_rns_sequencer                                               |
// | Purpose  : Stream-side controller for fir_rns. Collects one block of       |
// |            SIGNAL_COUNT samples, writes them into fir_rns (LOAD), starts   |
// |            the filter (COMPUTE), then reads each result back through the   |
// |            RNS->int convertor and streams it out (READ).                   |
// | Ports    : clk, reset (async, active-high)                                 |
// |            start/busy/err_timeout         block control and status        |
// |            in_valid/in_ready/in_data      sample input stream             |
// |            out_valid/out_ready/out_data/out_last  result output stream     |
// |            fir_addr/fir_x/fir_op          drive fir_rns                   |
// |            fir_y/fir_done                 returned from fir_rns path      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fir_rns_sequencer #(
  parameter int SIGNAL_COUNT = 10,
  parameter int N            = 10,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              err_timeout,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [31:0]       fir_addr,
  output logic [DATA_W-1:0] fir_x,
  output logic [1:0]        fir_op,
  input  logic [DATA_W-1:0] fir_y,
  input  logic              fir_done
);

  // N only travels to fir_rns; it is folded in as a zero term so it remains a
  // referenced parameter of this block.
  localparam int CNT_W  = ((SIGNAL_COUNT > 1) ? $clog2(SIGNAL_COUNT) : 1) + (N * 0);
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(SIGNAL_COUNT - 1);
  localparam logic [TCNT_W-1:0] C_TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [31:0]       C_ADDR_LAST = 32'(SIGNAL_COUNT - 1);

  // State encoding matches the fir_rns operation code, so fir_op is the state.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_LOAD    = 2'b01,
    S_COMPUTE = 2'b10,
    S_READ    = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  // In LOAD: last sample has been presented, hold op 01 one more cycle.
  // In READ: fir_addr just changed, give the convertor path one cycle.
  logic                wait_q, wait_d;
  logic [31:0]         fir_addr_q, fir_addr_d;
  logic [DATA_W-1:0]   fir_x_q, fir_x_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      wait_q      <= 1'b0;
      fir_addr_q  <= '0;
      fir_x_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      wait_q      <= wait_d;
      fir_addr_q  <= fir_addr_d;
      fir_x_q     <= fir_x_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    wait_d      = wait_q;
    fir_addr_d  = fir_addr_q;
    fir_x_d     = fir_x_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          cnt_d      = '0;
          wait_d     = 1'b0;
          fir_addr_d = '0;
          err_d      = 1'b0;
        end
      end

      S_LOAD: begin
        if (wait_q) begin
          // Final write has had its op-01 cycle; start the filter.
          state_d = S_COMPUTE;
          wait_d  = 1'b0;
          tcnt_d  = '0;
        end else if (in_valid) begin
          fir_x_d    = in_data;
          fir_addr_d = 32'(cnt_q);
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == C_CNT_LAST) begin
            cnt_d  = '0;
            wait_d = 1'b1;
          end
        end
      end

      S_COMPUTE: begin
        tcnt_d = tcnt_q + 1'b1;
        if (fir_done) begin
          state_d    = S_READ;
          fir_addr_d = '0;
          wait_d     = 1'b1;
        end else if (tcnt_q == C_TCNT_LAST) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          tcnt_d     = '0;
          fir_addr_d = '0;
        end
      end

      S_READ: begin
        if (wait_q) begin
          out_data_d  = fir_y;
          out_valid_d = 1'b1;
          out_last_d  = (fir_addr_q == C_ADDR_LAST);
          wait_d      = 1'b0;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d    = S_IDLE;
            fir_addr_d = '0;
          end else begin
            fir_addr_d = fir_addr_q + 32'd1;
            wait_d     = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign fir_op      = state_q;
  assign busy        = (state_q != S_IDLE);
  assign in_ready    = (state_q == S_LOAD) && !wait_q;
  assign err_timeout = err_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign fir_addr    = fir_addr_q;
  assign fir_x       = fir_x_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_rns_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fir_rns_sequencer                                            |
// | Purpose  : Self-checking bench for fir_rns_sequencer with a small fir_rns  |
// |            stand-in (memory + y = 3*x + 7) and a stream-level model.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fir_rns_sequencer;

  localparam int SC = 10;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, err_timeout;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic [31:0] fir_addr;
  logic [31:0] fir_x;
  logic [1:0]  fir_op;
  logic [31:0] fir_y;
  logic        fir_done;

  fir_rns_sequencer #(.SIGNAL_COUNT(SC), .N(10), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .err_timeout(err_timeout),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .fir_addr(fir_addr), .fir_x(fir_x), .fir_op(fir_op), .fir_y(fir_y), .fir_done(fir_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // ---------------- fir_rns stand-in ----------------
  logic [31:0] mem [0:SC-1];
  int          ccnt;
  logic        done_en = 1'b1;
  logic        spur = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) ccnt <= 0;
    else if (fir_op == 2'b10) ccnt <= ccnt + 1;
    else ccnt <= 0;
  end

  always @(posedge clk)
    if (fir_op == 2'b01 && fir_addr < SC) mem[fir_addr[3:0]] <= fir_x;

  assign fir_done = spur | (done_en && fir_op == 2'b10 && ccnt >= 5);
  assign fir_y    = (fir_addr < SC) ? mem[fir_addr[3:0]] * 32'd3 + 32'd7 : 32'd0;

  // ---------------- stream-level model and checker ----------------
  logic [31:0] smp [0:SC-1];
  logic [31:0] got [0:SC-1];
  int  exp_idx = 0, rk = 0, last_idx = 0, pend_idx = 0, comp_cycles = 0;
  bit  pend = 0, pend_last = 0, op_next = 0, beat_seen = 0, prev_stall = 0, clr_pend = 0;
  logic [31:0] pend_data, prev_d;
  logic        prev_l;

  always @(negedge clk) begin
    if (reset) begin
      pend = 0; op_next = 0; prev_stall = 0; beat_seen = 0;
      exp_idx = 0; rk = 0; clr_pend = 0;
    end else begin
      if (clr_pend) begin chk("err_cleared", {31'd0, err_timeout}, 32'd0); clr_pend = 0; end
      if (fir_op != 2'b01) chk("in_ready_off", {31'd0, in_ready}, 32'd0);
      chk("busy", {31'd0, busy}, {31'd0, fir_op != 2'b00});
      if (op_next) begin chk("op_compute", {30'd0, fir_op}, 32'd2); op_next = 0; end
      if (pend) begin
        chk("load_addr", fir_addr, 32'(pend_idx));
        chk("load_x", fir_x, pend_data);
        if (pend_last) begin chk("op_last_write", {30'd0, fir_op}, 32'd1); op_next = 1; end
        pend = 0;
      end else if (fir_op == 2'b01 && beat_seen) begin
        chk("load_hold", fir_addr, 32'(last_idx));
      end
      if (fir_op == 2'b10) comp_cycles++;
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", out_data, prev_d);
        chk("stall_last", {31'd0, out_last}, {31'd0, prev_l});
      end
      if (out_valid) begin
        chk("read_op", {30'd0, fir_op}, 32'd3);
        chk("read_addr", fir_addr, 32'(rk));
      end
      if (out_valid && out_ready) begin
        if (rk < SC) begin
          chk("result", out_data, smp[rk] * 32'd3 + 32'd7);
          chk("last", {31'd0, out_last}, {31'd0, rk == SC - 1});
          got[rk] = out_data;
        end else begin
          fail_now("extra_result");
        end
        rk++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      if (in_valid && in_ready) begin
        if (exp_idx < SC) begin
          pend = 1; pend_idx = exp_idx; pend_data = in_data;
          pend_last = (exp_idx == SC - 1);
          smp[exp_idx] = in_data;
          beat_seen = 1; last_idx = exp_idx;
          exp_idx++;
        end else begin
          fail_now("extra_beat");
        end
      end
      if (start && fir_op == 2'b00) begin
        exp_idx = 0; rk = 0; beat_seen = 0; comp_cycles = 0; clr_pend = 1;
      end
    end
  end

  // ---------------- output-ready driver ----------------
  int ready_mode = 0;
  initial begin : ready_drv
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_err"},   {31'd0, err_timeout}, 32'd0);
    chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_ovld"},  {31'd0, out_valid}, 32'd0);
    chk({tag, "_odata"}, out_data, 32'd0);
    chk({tag, "_olast"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_addr"},  fir_addr, 32'd0);
    chk({tag, "_x"},     fir_x, 32'd0);
    chk({tag, "_op"},    {30'd0, fir_op}, 32'd0);
  endtask

  task automatic do_reset_mid();
    @(posedge clk); #3;
    in_valid = 1'b0; start = 1'b0;
    reset = 1'b1;
    #1 check_zero_outputs("rst_mid");
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  // abort: 0 none, 1 reset after 4 load beats, 2 reset at first result
  task automatic run_block(input int gap, input int rmode, input bit den, input bit lit, input int abort);
    bit ok;
    int guard;
    ready_mode = rmode;
    done_en = den;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < SC; i++) begin
      if (abort == 1 && i == 4) begin do_reset_mid(); return; end
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        start = 1'b1;  // start while busy must be ignored
        @(posedge clk); #1;
      end
      start = 1'b0;
      in_valid = 1'b1;
      in_data = lit ? 32'(i) : $urandom;
      ok = 0;
      guard = 0;
      while (!ok && guard < 20) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!ok) begin fail_now("load_wait"); in_valid = 1'b0; return; end
    end
    in_valid = 1'b0;
    ok = 0;
    for (guard = 0; guard < 3000 && !ok; guard++) begin
      @(negedge clk);
      if (abort == 2 && out_valid) begin do_reset_mid(); return; end
      if (!busy) ok = 1;
    end
    if (!ok) fail_now("block_end");
    else if (den) begin
      chk("result_count", 32'(rk), 32'(SC));
      chk("compute_cycles", 32'(comp_cycles), 32'd6);
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Power-on reset, released mid-clock
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("por");
    #2 reset = 1'b0;

    // Samples 0..9, always ready: result k is 3k+7
    run_block(0, 0, 1'b1, 1'b1, 0);
    chk("lit_res0", got[0], 32'd7);
    chk("lit_res5", got[5], 32'd22);
    chk("lit_res9", got[9], 32'd34);
    chk("lit_mem9", mem[9], 32'd9);

    // Stalling downstream 1,0,0,1
    run_block(0, 1, 1'b1, 1'b0, 0);

    // Input gaps: a beat every third cycle, start pulses while busy
    run_block(2, 0, 1'b1, 1'b0, 0);

    // fir_done in IDLE is ignored
    @(posedge clk); #1 spur = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("spur_busy", {31'd0, busy}, 32'd0);
    chk("spur_op", {30'd0, fir_op}, 32'd0);
    @(posedge clk); #1 spur = 1'b0;

    // Timeout: no fir_done
    run_block(0, 0, 1'b0, 1'b0, 0);
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_op", {30'd0, fir_op}, 32'd0);
    chk("to_cycles", 32'(comp_cycles), 32'(TO));
    chk("to_no_result", 32'(rk), 32'd0);
    // Next block clears the error (checked right after start)
    run_block(0, 0, 1'b1, 1'b0, 0);

    // Reset mid-READ, then a clean block
    run_block(0, 1, 1'b1, 1'b0, 2);
    // Reset after 4 LOAD beats, then a full block restarts at address 0
    run_block(0, 0, 1'b1, 1'b0, 1);
    run_block(0, 0, 1'b1, 1'b0, 0);

    // Randomised traffic
    for (int r = 0; r < 4; r++)
      run_block($urandom_range(0, 2), 2, 1'b1, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
